// File: rtl/ring_meas_pkg.sv
// Shared types and constants for the ring-oscillator measurement scheduler.
// Holds the FSM state encoding, window/retry constants and the grey-to-binary helper.
package ring_meas_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_GATE    = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_SAMPLE  = 3'd4,
        ST_PRESENT = 3'd5
    } state_e;

    localparam int unsigned WIN_BASE  = 16;
    localparam int unsigned RETRY_MAX = 3;
    // Wide enough for the longest window, 16 << 15 cycles.
    localparam int unsigned CNT_W     = 20;

    // Each binary bit is the XOR of the grey bit at that position and all bits above it.
    function automatic logic [31:0] grey2bin(input logic [31:0] g);
        logic [31:0] b;
        b = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/ring_meas_sync.sv
// Parameterised-width two-flop synchroniser for the asynchronous ring grey count.
// Reset clears both stages to zero.
module ring_meas_sync #(
    parameter int unsigned pW = 15
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [pW-1:0] d_i,
    output logic [pW-1:0] q_o
);

    logic [pW-1:0] meta_q;
    logic [pW-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/ring_meas_sched.sv
// Round-robin ring-oscillator measurement scheduler: clear, gate, settle, sample, present.
// Optional macro RING_MEAS_STABLE_EN enables the sample-stability retry and o_err reporting.
module ring_meas_sched #(
    parameter int unsigned pCHAN   = 5,
    parameter int unsigned pWIDTH  = 15,
    parameter int unsigned pSETTLE = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_start,
    input  logic [pCHAN-1:0]           i_mask,
    input  logic [3:0]                 i_win,
    input  logic [pWIDTH-1:0]          i_grey,
    input  logic                       i_rdy,
    output logic [$clog2(pCHAN)-1:0]   o_sel,
    output logic [pCHAN-1:0]           o_clr,
    output logic [pCHAN-1:0]           o_gate,
    output logic [pWIDTH-1:0]          o_data,
    output logic [$clog2(pCHAN)-1:0]   o_ch,
    output logic                       o_vld,
    output logic                       o_err,
    output logic                       o_busy
);

    import ring_meas_pkg::*;

    localparam int unsigned SELW = $clog2(pCHAN);
    localparam logic [pCHAN-1:0] ONE_HOT0 = pCHAN'(1);

    state_e            state_q, state_d;
    logic [SELW-1:0]   ptr_q, ptr_d;
    logic [SELW-1:0]   sel_q, sel_d;
    logic [SELW-1:0]   ch_q, ch_d;
    logic [SELW-1:0]   ch_wrap;
    logic [SELW-1:0]   pick, idx;
    logic              pick_ok;
    logic [3:0]        win_q, win_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [pWIDTH-1:0] data_q, data_d;
    logic [pWIDTH-1:0] grey_s;
`ifdef RING_MEAS_STABLE_EN
    logic [pWIDTH-1:0] grey_prev_q;
    logic [1:0]        retry_q, retry_d;
    logic              err_q, err_d;
`endif

    ring_meas_sync #(.pW(pWIDTH)) u_sync (
        .clk_i (i_clk),
        .rst_i (i_rst),
        .d_i   (i_grey),
        .q_o   (grey_s)
    );

    // Pointer advances on the transfer cycle so the same-cycle pick already sees it.
    assign ch_wrap = (ch_q == SELW'(pCHAN - 1)) ? '0 : ch_q + SELW'(1);

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == ST_PRESENT && i_rdy) begin
            ptr_d = ch_wrap;
        end
    end

    always_comb begin
        pick    = '0;
        pick_ok = 1'b0;
        idx     = '0;
        for (int unsigned i = 0; i < pCHAN; i++) begin
            idx = SELW'((32'(ptr_d) + i) % pCHAN);
            if (!pick_ok && i_mask[idx]) begin
                pick    = idx;
                pick_ok = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        win_d   = win_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        ch_d    = ch_q;
`ifdef RING_MEAS_STABLE_EN
        retry_d = retry_q;
        err_d   = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_start && pick_ok) begin
                    state_d = ST_CLEAR;
                    sel_d   = pick;
                    win_d   = i_win;
                    cnt_d   = CNT_W'(pSETTLE - 1);
                end
            end
            ST_CLEAR: begin
                if (cnt_q == '0) begin
                    state_d = ST_GATE;
                    cnt_d   = (CNT_W'(WIN_BASE) << win_q) - CNT_W'(1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_GATE: begin
                if (cnt_q == '0) begin
                    state_d = ST_SETTLE;
                    cnt_d   = CNT_W'(pSETTLE - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_SAMPLE;
`ifdef RING_MEAS_STABLE_EN
                    retry_d = '0;
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_SAMPLE: begin
                data_d = pWIDTH'(grey2bin(32'(grey_s)));
                ch_d   = sel_q;
`ifdef RING_MEAS_STABLE_EN
                if (grey_s == grey_prev_q) begin
                    err_d   = 1'b0;
                    state_d = ST_PRESENT;
                end else if (retry_q == 2'(RETRY_MAX - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_PRESENT;
                end else begin
                    retry_d = retry_q + 2'd1;
                end
`else
                state_d = ST_PRESENT;
`endif
            end
            ST_PRESENT: begin
                if (i_rdy) begin
                    state_d = ST_IDLE;
                    if (i_start && pick_ok) begin
                        state_d = ST_CLEAR;
                        sel_d   = pick;
                        win_d   = i_win;
                        cnt_d   = CNT_W'(pSETTLE - 1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            win_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            ch_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            win_q   <= win_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
        end
    end

`ifdef RING_MEAS_STABLE_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            grey_prev_q <= '0;
            retry_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            grey_prev_q <= grey_s;
            retry_q     <= retry_d;
            err_q       <= err_d;
        end
    end
    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

    assign o_sel  = sel_q;
    assign o_clr  = (state_q == ST_CLEAR) ? (ONE_HOT0 << sel_q) : '0;
    assign o_gate = (state_q == ST_GATE)  ? (ONE_HOT0 << sel_q) : '0;
    assign o_data = data_q;
    assign o_ch   = ch_q;
    assign o_vld  = (state_q == ST_PRESENT);
    assign o_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ring_meas_sched.sv
// Scoreboard bench for ring_meas_sched: a behavioural ring-counter environment feeds grey counts,
// a round-robin model predicts each result, and a negedge monitor checks outputs and timing.
module tb_ring_meas_sched;

    localparam int C  = 5;
    localparam int WD = 15;
    localparam int S  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [C-1:0]  mask;
    logic [3:0]    win;
    logic [WD-1:0] grey;
    logic          rdy;
    logic [2:0]    o_sel;
    logic [C-1:0]  o_clr;
    logic [C-1:0]  o_gate;
    logic [WD-1:0] o_data;
    logic [2:0]    o_ch;
    logic          o_vld;
    logic          o_err;
    logic          o_busy;

    always #5 clk = ~clk;

    ring_meas_sched #(.pCHAN(C), .pWIDTH(WD), .pSETTLE(S)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (start),
        .i_mask  (mask),
        .i_win   (win),
        .i_grey  (grey),
        .i_rdy   (rdy),
        .o_sel   (o_sel),
        .o_clr   (o_clr),
        .o_gate  (o_gate),
        .o_data  (o_data),
        .o_ch    (o_ch),
        .o_vld   (o_vld),
        .o_err   (o_err),
        .o_busy  (o_busy)
    );

    typedef struct {
        int ch;
        int data;
    } exp_t;

    exp_t sbq[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   step[C];
    int   ring_cnt[C];
    bit   fixed_mode  = 0;
    bit   rnd_rdy     = 0;
    int   hold_left   = 0;
    int   cur_W       = 16;
    int   ptr_m       = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int model_pick(input logic [C-1:0] m, input int p);
        for (int i = 0; i < C; i++) begin
            if (m[(p + i) % C]) return (p + i) % C;
        end
        return -1;
    endfunction

    // Predict the next n results: round-robin channel, count = W gate cycles times ring speed.
    task automatic issue(input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.ch   = model_pick(mask, ptr_m);
            e.data = fixed_mode ? 6 : ((cur_W * step[e.ch]) % (1 << WD));
            sbq.push_back(e);
            ptr_m  = (e.ch + 1) % C;
        end
    endtask

    task automatic wait_idle();
        int budget = 0;
        while ((sbq.size() != 0 || o_busy) && budget < 30000) begin
            @(posedge clk); #1;
            budget++;
        end
        if (budget >= 30000) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sbq.size());
        end
    endtask

    task automatic run(input logic [C-1:0] m, input logic [3:0] w, input int n, input bit fixed);
        int  g = 0;
        bit  pg = 0;
        int  budget = 0;
        mask       = m;
        win        = w;
        cur_W      = 16 << w;
        fixed_mode = fixed;
        for (int c = 0; c < C; c++) step[c] = $urandom_range(1, 2047);
        issue(n);
        start = 1'b1;
        // Drop start inside the gate window of the last expected measurement.
        while (g < n && budget < 30000) begin
            @(posedge clk); #1;
            if (|o_gate && !pg) g++;
            pg = |o_gate;
            budget++;
        end
        start = 1'b0;
        if (budget >= 30000) begin
            vectors++;
            miscompares++;
            $display("FAIL gate_timeout: got %0d gates expected %0d", g, n);
        end
        wait_idle();
    endtask

    // Ring-counter environment: counts while gated, clears on o_clr, muxed by o_sel.
    always @(negedge clk) begin
        int b;
        for (int c = 0; c < C; c++) begin
            if (rst || o_clr[c]) ring_cnt[c] = 0;
            else if (o_gate[c]) ring_cnt[c] = ring_cnt[c] + step[c];
        end
        b    = fixed_mode ? 6 : (ring_cnt[o_sel] % (1 << WD));
        grey = WD'(b ^ (b >> 1));
    end

    int           ncyc = 0;
    int           t_clr = 0;
    int           grun = 0;
    int           crun = 0;
    logic [C-1:0] prev_gate = '0;
    logic [C-1:0] prev_clr = '0;
    bit           prev_vld = 0;
    bit           pend = 0;
    bit           after_xfer = 0;
    bit           start_at_xfer = 0;

    always @(negedge clk) begin
        if (rst) begin
            prev_gate  = '0;
            prev_clr   = '0;
            prev_vld   = 0;
            pend       = 0;
            after_xfer = 0;
            grun       = 0;
            crun       = 0;
        end else begin
            ncyc++;
            if (after_xfer) begin
                if (start_at_xfer && sbq.size() > 0) chk("b2b_clr", o_clr, 1 << sbq[0].ch);
                else chk("idle_after_xfer", o_busy, 0);
            end
            if (pend) chk("hold_vld", o_vld, 1);
            if (o_clr != 0) begin
                if (prev_clr == 0) begin
                    t_clr = ncyc;
                    crun  = 0;
                    if (sbq.size() > 0) chk("clr_chan", o_clr, 1 << sbq[0].ch);
                end
                crun++;
            end else if (prev_clr != 0) begin
                chk("clr_len", crun, S);
            end
            if (o_gate != 0) begin
                if (prev_gate == 0) begin
                    grun = 0;
                    if (sbq.size() > 0) chk("gate_chan", o_gate, 1 << sbq[0].ch);
                    else chk("gate_in_mask", o_gate & ~mask, 0);
                end
                grun++;
            end else if (prev_gate != 0) begin
                chk("gate_len", grun, cur_W);
            end
            if (o_vld && !prev_vld) chk("vld_latency", ncyc - t_clr, 2 * S + cur_W + 1);

            if (hold_left > 0 && o_vld) begin
                rdy = 1'b0;
                hold_left--;
            end else begin
                rdy = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
            end

            after_xfer = 0;
            if (o_vld) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_vld", o_vld, 0);
                end else begin
                    chk("data", o_data, sbq[0].data);
                    chk("ch", o_ch, sbq[0].ch);
                    chk("err", o_err, 0);
                    if (rdy) begin
                        void'(sbq.pop_front());
                        after_xfer    = 1;
                        start_at_xfer = start;
                    end
                end
            end
            pend      = o_vld && !rdy;
            prev_vld  = o_vld;
            prev_gate = o_gate;
            prev_clr  = o_clr;
        end
    end

    initial begin
        logic [C-1:0] m;
        int           budget;
        rst   = 1'b1;
        start = 1'b0;
        mask  = '0;
        win   = '0;
        rdy   = 1'b1;
        for (int c = 0; c < C; c++) step[c] = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs", {o_sel, o_clr, o_gate, o_data, o_ch, o_vld, o_err, o_busy}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single channel, grey 0x0005 -> binary 6, repeated re-measurement.
        run(5'b00001, 4'd0, 3, 1'b1);

        // Alternating channels 2 and 4 under random back-pressure.
        rnd_rdy = 1;
        run(5'b10100, 4'd1, 4, 1'b0);

        // Consumer stalls for 20 cycles on the first result.
        hold_left = 20;
        run(C'($urandom_range(1, 31)), 4'd0, 2, 1'b0);

        // All-zero mask must never leave IDLE.
        mask  = '0;
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            repeat (10) @(posedge clk);
            #1;
            chk("zero_mask_idle", o_busy, 0);
        end
        start = 1'b0;

        for (int r = 0; r < 6; r++) begin
            run(C'($urandom_range(1, 31)), 4'($urandom_range(0, 3)), $urandom_range(1, 5), 1'b0);
        end

        // Asynchronous reset in the middle of a gate window.
        m     = C'($urandom_range(1, 31));
        mask  = m;
        win   = 4'd1;
        cur_W = 32;
        issue(3);
        start  = 1'b1;
        budget = 0;
        while (!(|o_gate) && budget < 1000) begin
            @(posedge clk); #1;
            budget++;
        end
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_mid_gate", {o_sel, o_clr, o_gate, o_data, o_ch, o_vld, o_err, o_busy}, 0);
        start = 1'b0;
        sbq.delete();
        ptr_m = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        run(m | C'(1), 4'd0, 1, 1'b0);

        // Long window.
        run(C'($urandom_range(1, 31)), 4'd5, 1, 1'b0);

        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
